gb_cpu_interrupt_controller: RTL and testbench
==============================================

// Module: gb_cpu_interrupt_controller
// PURPOSE
// - Interrupt-side endpoint of the scheduler dispatch handshake: owns IF (0xFF0F), IE (0xFFFF), IME.
// - Raises interrupt_queued for the scheduler; services write_interrupt_vector / clear_interrupt_flag.
// - Implements EI one-instruction delay, DI, priority select, HALT wake.
// PARAMETERS
// - NUM_IRQ      5        interrupt sources; bit0 = highest priority (VBlank,STAT,Timer,Serial,Joypad)
// - IF_ADDR      16'hFF0F memory-mapped IF address
// - IE_ADDR      16'hFFFF memory-mapped IE address
// - VECTOR_BASE  8'h40    vector of source 0; source n -> VECTOR_BASE + 8*n
// PORTS
// - clk                    in   1        machine (M) clock
// - reset                  in   1        asynchronous, active-high
// - irq_sources            in   NUM_IRQ  peripheral request lines
// - mem_addr               in   16       CPU bus address
// - mem_wdata              in   8        CPU bus write data
// - mem_wren               in   1        bus write strobe, one cycle
// - mem_rdata              out  8        read data for IF/IE, 8'hFF otherwise
// - mem_hit                out  1        mem_addr decodes to IF or IE (combinational)
// - instr_boundary         in   1        scheduler is fetching next opcode (curr_m_cycle==0)
// - enable_interrupts      in   1        EI control strobe
// - disable_interrupts     in   1        DI control strobe
// - write_interrupt_vector in   1        dispatch: latch winning source, drive vector
// - clear_interrupt_flag   in   1        dispatch: clear latched IF bit, drop IME
// - interrupt_queued       out  1        IME & |(IE & IF)
// - int_vector             out  8        latched dispatch target address
// - ime                    out  1        master enable (state==IME_ON)
// - halt_wake              out  1        |(IE & IF), independent of IME
// BEHAVIOUR
// - Reset: IF=0, IE=0, IME state OFF, dispatch IDLE, int_vector=8'h00, irq_prev=0; all outputs 0 except mem_rdata.
// - IF read: {3'b111, IF[4:0]}; IE read/write: all 8 bits; IF write stores bits [4:0] only.
// - Request set: IF[n] <= 1 on request event for n (see CONFIGURATION); set wins over same-cycle bus write 0 or dispatch clear.
// - pending = IE[4:0] & IF[4:0]; interrupt_queued, halt_wake combinational from registered state.
// - IME FSM: OFF -EI-> ARM; ARM -instr_boundary (cycle after EI or later)-> ON; any -DI-> OFF.
//   - DI and EI same cycle: DI wins (OFF). EI while ON: stays ON. EI and instr_boundary same cycle: ARM only.
// - Dispatch FSM: IDLE -write_interrupt_vector-> LATCHED; LATCHED -clear_interrupt_flag-> IDLE.
//   - On latch: idx = lowest set bit of pending; int_vector = VECTOR_BASE + 8*idx; pending==0 -> int_vector=8'h00, idx invalid.
//   - On clear: IF[idx] <= 0 (if valid), IME -> OFF; clear in IDLE: ignored.
//   - write_interrupt_vector in LATCHED: re-latch from current pending.
// - Late IE/IF change between latch and clear does not alter latched idx/vector.
// - Reset mid-dispatch: immediate return to reset values, no IF bit cleared.
// CONFIGURATION
// - GB_CPU_INT_IRQ_EDGE_EN defined: irq_sources registered into irq_prev; request event = rising edge (src & ~irq_prev).
//   Held-high source sets IF once; re-request needs low-then-high.
// - Undefined: request event = irq_sources level each cycle; peripherals must pulse for one cycle; irq_prev removed.
// TESTING
// - IE=8'h05, pulse src0 and src2 same cycle -> IF=5'h05, halt_wake=1, interrupt_queued=0 (IME OFF), mem_rdata@FF0F=8'hE5.
// - EI, then instr_boundary next cycle -> ime=1 that cycle+1, interrupt_queued=1; EI+DI same cycle -> ime stays 0.
// - IME ON, IE=8'h1F, IF=5'h14: write_interrupt_vector -> int_vector=8'h50; clear -> IF=5'h10, ime=0.
// - Latch then IE=0 before clear -> int_vector stays 8'h50, IF[2] still cleared; latch with pending=0 -> int_vector=8'h00.
// - src1 pulse in same cycle as clear of IF[1] -> IF[1]=1 after; held-high src (EDGE_EN) after bus clear -> IF stays 0.
// - Assert reset while LATCHED -> IF=0, IE=0, ime=0, int_vector=8'h00 asynchronously.

Source files
------------

// File: rtl/gb_cpu_interrupt_controller.sv
// Game Boy CPU interrupt controller: owns IF (0xFF0F), IE (0xFFFF) and IME; scheduler dispatch endpoint.
// Latency: register writes/requests/IME changes take effect one M-cycle later; queued/wake/rdata/hit are combinational.
// Backpressure: none; dispatch is a strobe handshake (write_interrupt_vector latches, clear_interrupt_flag retires).
//
// Optional build macro: GB_CPU_INT_IRQ_EDGE_EN
//   defined   -> requests are rising edges of irq_sources (held-high line sets IF once)
//   undefined -> requests are irq_sources levels sampled every cycle (peripherals pulse one cycle)
//
// Ports:
//   clk, reset                      M-cycle clock, asynchronous active-high reset
//   irq_sources                     peripheral request lines, bit0 = highest priority
//   mem_addr/mem_wdata/mem_wren     CPU bus write side; mem_rdata/mem_hit bus read side
//   instr_boundary                  scheduler is fetching the next opcode
//   enable_interrupts               EI strobe
//   disable_interrupts              DI strobe
//   write_interrupt_vector          dispatch: latch winning source and its vector
//   clear_interrupt_flag            dispatch: retire latched IF bit, drop IME
//   interrupt_queued                IME & |(IE & IF)
//   int_vector                      latched dispatch target
//   ime                             master enable
//   halt_wake                       |(IE & IF), ignores IME
module gb_cpu_interrupt_controller #(
    parameter int          NUM_IRQ     = 5,
    parameter logic [15:0] IF_ADDR     = 16'hFF0F,
    parameter logic [15:0] IE_ADDR     = 16'hFFFF,
    parameter logic [7:0]  VECTOR_BASE = 8'h40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_sources,
    input  logic [15:0]        mem_addr,
    input  logic [7:0]         mem_wdata,
    input  logic               mem_wren,
    output logic [7:0]         mem_rdata,
    output logic               mem_hit,
    input  logic               instr_boundary,
    input  logic               enable_interrupts,
    input  logic               disable_interrupts,
    input  logic               write_interrupt_vector,
    input  logic               clear_interrupt_flag,
    output logic               interrupt_queued,
    output logic [7:0]         int_vector,
    output logic               ime,
    output logic               halt_wake
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        IME_OFF = 2'd0,
        IME_ARM = 2'd1,
        IME_ON  = 2'd2
    } ime_state_t;

    typedef enum logic {
        DISP_IDLE    = 1'b0,
        DISP_LATCHED = 1'b1
    } disp_state_t;

    logic [NUM_IRQ-1:0] if_q, if_d;
    logic [7:0]         ie_q, ie_d;
    ime_state_t         ime_q, ime_d;
    disp_state_t        disp_q, disp_d;
    logic [7:0]         vec_q, vec_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               idx_vld_q, idx_vld_d;

    logic [NUM_IRQ-1:0] irq_req;
    logic [NUM_IRQ-1:0] pending;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic [7:0]         win_vec;
    logic               do_clear;
    logic               if_sel;
    logic               ie_sel;

`ifdef GB_CPU_INT_IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] irq_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev_q <= '0;
        end else begin
            irq_prev_q <= irq_sources;
        end
    end

    assign irq_req = irq_sources & ~irq_prev_q;
`else
    assign irq_req = irq_sources;
`endif

    assign if_sel  = (mem_addr == IF_ADDR);
    assign ie_sel  = (mem_addr == IE_ADDR);
    assign mem_hit = if_sel | ie_sel;

    assign pending          = ie_q[NUM_IRQ-1:0] & if_q;
    assign halt_wake        = |pending;
    assign ime              = (ime_q == IME_ON);
    assign interrupt_queued = ime & halt_wake;
    assign int_vector       = vec_q;

    // Unimplemented IF bits read back as 1, like the real register.
    always_comb begin
        mem_rdata = 8'hFF;
        if (if_sel) begin
            mem_rdata[NUM_IRQ-1:0] = if_q;
        end else if (ie_sel) begin
            mem_rdata = ie_q;
        end
    end

    // Lowest set pending bit wins: scan downwards so the last hit is the lowest index.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win_idx = IDX_W'(i);
                win_vld = 1'b1;
            end
        end
    end

    assign win_vec = win_vld ? (VECTOR_BASE + (8'(win_idx) << 3)) : 8'h00;

    // A clear outside a dispatch is ignored entirely.
    assign do_clear = clear_interrupt_flag && (disp_q == DISP_LATCHED);

    always_comb begin
        if_d      = if_q;
        ie_d      = ie_q;
        ime_d     = ime_q;
        disp_d    = disp_q;
        vec_d     = vec_q;
        idx_d     = idx_q;
        idx_vld_d = idx_vld_q;

        // Dispatch FSM: the winner is frozen at latch time so later IE/IF
        // traffic cannot retarget the vector or the bit being retired.
        case (disp_q)
            DISP_IDLE: begin
                if (write_interrupt_vector) begin
                    disp_d    = DISP_LATCHED;
                    vec_d     = win_vec;
                    idx_d     = win_idx;
                    idx_vld_d = win_vld;
                end
            end
            DISP_LATCHED: begin
                if (clear_interrupt_flag) begin
                    disp_d = DISP_IDLE;
                end else if (write_interrupt_vector) begin
                    vec_d     = win_vec;
                    idx_d     = win_idx;
                    idx_vld_d = win_vld;
                end
            end
            default: disp_d = DISP_IDLE;
        endcase

        if (mem_wren && if_sel) begin
            if_d = mem_wdata[NUM_IRQ-1:0];
        end
        if (mem_wren && ie_sel) begin
            ie_d = mem_wdata;
        end
        if (do_clear && idx_vld_q) begin
            if_d[idx_q] = 1'b0;
        end
        // New requests are applied last so they beat a same-cycle clear.
        if_d = if_d | irq_req;

        // IME FSM: ARM delays enabling until the next opcode fetch after EI.
        if (disable_interrupts || do_clear) begin
            ime_d = IME_OFF;
        end else begin
            case (ime_q)
                IME_OFF: if (enable_interrupts) ime_d = IME_ARM;
                IME_ARM: if (instr_boundary && !enable_interrupts) ime_d = IME_ON;
                IME_ON:  ime_d = IME_ON;
                default: ime_d = IME_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_q      <= '0;
            ie_q      <= 8'h00;
            ime_q     <= IME_OFF;
            disp_q    <= DISP_IDLE;
            vec_q     <= 8'h00;
            idx_q     <= '0;
            idx_vld_q <= 1'b0;
        end else begin
            if_q      <= if_d;
            ie_q      <= ie_d;
            ime_q     <= ime_d;
            disp_q    <= disp_d;
            vec_q     <= vec_d;
            idx_q     <= idx_d;
            idx_vld_q <= idx_vld_d;
        end
    end

endmodule

// File: tb/tb_gb_cpu_interrupt_controller.sv
// Directed bench for gb_cpu_interrupt_controller.
// Inputs change 1 ns after the rising edge; outputs are checked in the same window.
module tb_gb_cpu_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] irq_sources;
    logic [15:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wren;
    logic [7:0] mem_rdata;
    logic       mem_hit;
    logic       instr_boundary;
    logic       enable_interrupts;
    logic       disable_interrupts;
    logic       write_interrupt_vector;
    logic       clear_interrupt_flag;
    logic       interrupt_queued;
    logic [7:0] int_vector;
    logic       ime;
    logic       halt_wake;

    int tests    = 0;
    int failures = 0;

    gb_cpu_interrupt_controller dut (
        .clk                    (clk),
        .reset                  (reset),
        .irq_sources            (irq_sources),
        .mem_addr               (mem_addr),
        .mem_wdata              (mem_wdata),
        .mem_wren               (mem_wren),
        .mem_rdata              (mem_rdata),
        .mem_hit                (mem_hit),
        .instr_boundary         (instr_boundary),
        .enable_interrupts      (enable_interrupts),
        .disable_interrupts     (disable_interrupts),
        .write_interrupt_vector (write_interrupt_vector),
        .clear_interrupt_flag   (clear_interrupt_flag),
        .interrupt_queued       (interrupt_queued),
        .int_vector             (int_vector),
        .ime                    (ime),
        .halt_wake              (halt_wake)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        mem_addr  = addr;
        mem_wdata = data;
        mem_wren  = 1'b1;
        tick();
        mem_wren  = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        mem_addr = addr;
        #1;
        check(tag, mem_rdata, exp);
    endtask

    initial begin
        reset                  = 1'b1;
        irq_sources            = '0;
        mem_addr               = 16'h0000;
        mem_wdata              = 8'h00;
        mem_wren               = 1'b0;
        instr_boundary         = 1'b0;
        enable_interrupts      = 1'b0;
        disable_interrupts     = 1'b0;
        write_interrupt_vector = 1'b0;
        clear_interrupt_flag   = 1'b0;
        #3;
        check("rst_iq",    {7'b0, interrupt_queued}, 8'h00);
        check("rst_ime",   {7'b0, ime},              8'h00);
        check("rst_wake",  {7'b0, halt_wake},        8'h00);
        check("rst_vec",   int_vector,               8'h00);
        check("rst_hit",   {7'b0, mem_hit},          8'h00);
        check("rst_rdata", mem_rdata,                8'hFF);
        tick();
        tick();
        reset = 1'b0;

        // Register readback
        rd_check("if_rst", 16'hFF0F, 8'hE0);
        check("hit_if", {7'b0, mem_hit}, 8'h01);
        rd_check("ie_rst", 16'hFFFF, 8'h00);
        wr(16'hFFFF, 8'h05);
        rd_check("ie_wr", 16'hFFFF, 8'h05);

        // Two simultaneous requests with IME off
        irq_sources = 5'b00101;
        tick();
        irq_sources = '0;
        rd_check("if_req", 16'hFF0F, 8'hE5);
        check("wake_req", {7'b0, halt_wake},        8'h01);
        check("iq_imeoff", {7'b0, interrupt_queued}, 8'h00);

        // EI and DI together: DI wins, boundary afterwards changes nothing
        enable_interrupts  = 1'b1;
        disable_interrupts = 1'b1;
        tick();
        enable_interrupts  = 1'b0;
        disable_interrupts = 1'b0;
        instr_boundary     = 1'b1;
        tick();
        instr_boundary     = 1'b0;
        check("ime_eidi", {7'b0, ime}, 8'h00);

        // EI then boundary next cycle
        enable_interrupts = 1'b1;
        tick();
        enable_interrupts = 1'b0;
        check("ime_arm", {7'b0, ime}, 8'h00);
        instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        check("ime_on", {7'b0, ime},              8'h01);
        check("iq_on",  {7'b0, interrupt_queued}, 8'h01);

        // Dispatch of Timer (bit 2) over Joypad (bit 4)
        wr(16'hFFFF, 8'h1F);
        wr(16'hFF0F, 8'h14);
        rd_check("if_14", 16'hFF0F, 8'hF4);
        write_interrupt_vector = 1'b1;
        tick();
        write_interrupt_vector = 1'b0;
        check("vec_timer", int_vector, 8'h50);
        clear_interrupt_flag = 1'b1;
        tick();
        clear_interrupt_flag = 1'b0;
        rd_check("if_clr", 16'hFF0F, 8'hF0);
        check("ime_clr", {7'b0, ime},              8'h00);
        check("iq_clr",  {7'b0, interrupt_queued}, 8'h00);
        check("wake_j",  {7'b0, halt_wake},        8'h01);

        // IE dropped between latch and clear
        wr(16'hFF0F, 8'h14);
        write_interrupt_vector = 1'b1;
        tick();
        write_interrupt_vector = 1'b0;
        wr(16'hFFFF, 8'h00);
        check("wake_ie0", {7'b0, halt_wake}, 8'h00);
        check("vec_hold", int_vector,        8'h50);
        clear_interrupt_flag = 1'b1;
        tick();
        clear_interrupt_flag = 1'b0;
        rd_check("if_late", 16'hFF0F, 8'hF0);

        // Latch with nothing pending
        write_interrupt_vector = 1'b1;
        tick();
        write_interrupt_vector = 1'b0;
        check("vec_none", int_vector, 8'h00);
        clear_interrupt_flag = 1'b1;
        tick();
        clear_interrupt_flag = 1'b0;
        rd_check("if_none", 16'hFF0F, 8'hF0);

        // New request beats a same-cycle clear of the same bit
        wr(16'hFFFF, 8'h1F);
        wr(16'hFF0F, 8'h02);
        write_interrupt_vector = 1'b1;
        tick();
        write_interrupt_vector = 1'b0;
        check("vec_stat", int_vector, 8'h48);
        clear_interrupt_flag = 1'b1;
        irq_sources          = 5'b00010;
        tick();
        clear_interrupt_flag = 1'b0;
        irq_sources          = '0;
        rd_check("if_race", 16'hFF0F, 8'hE2);

        // Held-high source after a bus clear
        wr(16'hFF0F, 8'h00);
        irq_sources = 5'b01000;
        tick();
        rd_check("if_held", 16'hFF0F, 8'hE8);
        wr(16'hFF0F, 8'h00);
        tick();
`ifdef GB_CPU_INT_IRQ_EDGE_EN
        rd_check("if_held_clr", 16'hFF0F, 8'hE0);
`else
        rd_check("if_held_clr", 16'hFF0F, 8'hE8);
`endif
        irq_sources = '0;

        // Asynchronous reset during a latched dispatch with IME on
        wr(16'hFF0F, 8'h08);
        enable_interrupts = 1'b1;
        tick();
        enable_interrupts = 1'b0;
        instr_boundary    = 1'b1;
        tick();
        instr_boundary    = 1'b0;
        check("ime_pre", {7'b0, ime}, 8'h01);
        write_interrupt_vector = 1'b1;
        tick();
        write_interrupt_vector = 1'b0;
        check("vec_serial", int_vector, 8'h58);
        reset = 1'b1;
        #1;
        check("arst_ime", {7'b0, ime}, 8'h00);
        check("arst_vec", int_vector,  8'h00);
        rd_check("arst_if", 16'hFF0F, 8'hE0);
        rd_check("arst_ie", 16'hFFFF, 8'h00);
        tick();
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
